// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer: front-end PC control with redirect arbitration, stall-time
// redirect buffering, IF/ID flush strobes and boot/run/halt sequencing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] fetch_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        redirect_pending,
  output logic        misalign,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] TRAP_ALIGNED = {TRAP_VEC[31:2], 2'b00};
  localparam logic [1:0]  PRIO_NONE = 2'd0;
  localparam logic [1:0]  PRIO_JMP  = 2'd1;
  localparam logic [1:0]  PRIO_BR   = 2'd2;
  localparam logic [1:0]  PRIO_TRAP = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [1:0]  pprio_q, pprio_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        pmis_q, pmis_d;

  logic [1:0]  live_prio;
  logic [31:0] live_tgt;
  logic        live_mis;

  // Highest-priority live request; targets are word-aligned here so the
  // pending buffer and the PC only ever hold aligned addresses.
  always_comb begin
    live_prio = PRIO_NONE;
    live_tgt  = 32'h0;
    live_mis  = 1'b0;
    if (trap_req) begin
      live_prio = PRIO_TRAP;
      live_tgt  = TRAP_ALIGNED;
    end else if (br_req) begin
      live_prio = PRIO_BR;
      live_tgt  = {br_target[31:2], 2'b00};
      live_mis  = |br_target[1:0];
    end else if (jmp_req) begin
      live_prio = PRIO_JMP;
      live_tgt  = {jmp_target[31:2], 2'b00};
      live_mis  = |jmp_target[1:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pend_d           = pend_q;
    pprio_d          = pprio_q;
    ptgt_d           = ptgt_q;
    pmis_d           = pmis_q;
    fetch_addr       = pc_q;
    fetch_valid      = 1'b0;
    flush_if         = 1'b0;
    flush_id         = 1'b0;
    misalign         = 1'b0;
    halted           = 1'b0;
    redirect_pending = pend_q;

    case (state_q)
      ST_BOOT: begin
        fetch_addr = RESET_PC;
        pc_d       = RESET_PC;
        state_d    = ST_RUN;
      end

      ST_RUN: begin
        fetch_valid = 1'b1;
        flush_if    = trap_req | br_req | jmp_req;
        flush_id    = trap_req | br_req;
        if (stall) begin
          // Equal priority overwrites so the newest target of a class wins.
          if (live_prio != PRIO_NONE && (!pend_q || live_prio >= pprio_q)) begin
            pend_d  = 1'b1;
            pprio_d = live_prio;
            ptgt_d  = live_tgt;
            pmis_d  = live_mis;
          end
        end else begin
          if (live_prio != PRIO_NONE) begin
            fetch_addr = live_tgt;
            misalign   = live_mis;
          end else if (pend_q) begin
            fetch_addr = ptgt_q;
            misalign   = pmis_q;
          end else begin
            fetch_addr = pc_q + 32'd4;
          end
          pc_d   = fetch_addr;
          pend_d = 1'b0;
          if (halt_req) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        halted = 1'b1;
        pend_d = 1'b0;
        if (trap_req) begin
          flush_if   = 1'b1;
          flush_id   = 1'b1;
          fetch_addr = TRAP_ALIGNED;
          pc_d       = TRAP_ALIGNED;
          state_d    = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      pprio_q <= PRIO_NONE;
      ptgt_q  <= 32'h0;
      pmis_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      pprio_q <= pprio_d;
      ptgt_q  <= ptgt_d;
      pmis_q  <= pmis_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer: directed vector table plus randomized run against a
// queue-based reference model of the fetch sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, br_req, jmp_req, trap_req, halt_req, resume;
  logic [31:0] br_target, jmp_target;
  logic [31:0] fetch_addr, pc;
  logic        fetch_valid, flush_if, flush_id, redirect_pending, misalign, halted;

  fetch_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_req(br_req), .br_target(br_target),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume),
    .fetch_addr(fetch_addr), .pc(pc), .fetch_valid(fetch_valid),
    .flush_if(flush_if), .flush_id(flush_id),
    .redirect_pending(redirect_pending), .misalign(misalign), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n, stall, trap, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        halt, res;
  } in_t;

  typedef struct packed {
    logic [31:0] pc, fa;
    logic        fv, fi, fd, rp, mis, hl;
  } out_t;

  typedef struct {
    logic chk;
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct {
    int          prio;
    logic [31:0] tgt;
    bit          mis;
  } req_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=boot, 1=run, 2=halt; pending buffer is a queue.
  int          m_mode = 0;
  logic [31:0] m_pc   = RESET_PC;
  req_t        m_pend[$];

  function automatic req_t best_live(in_t i, output bit any);
    req_t r[$];
    if (i.trap) r.push_back('{3, TRAP_VEC & ~32'h3, 1'b0});
    if (i.br)   r.push_back('{2, i.bt & ~32'h3, i.bt[1:0] != 2'b00});
    if (i.jmp)  r.push_back('{1, i.jt & ~32'h3, i.jt[1:0] != 2'b00});
    any = (r.size() != 0);
    return any ? r[0] : '{0, 32'h0, 1'b0};
  endfunction

  function automatic out_t model_out(in_t i);
    out_t o;
    bit   any;
    req_t b;
    o    = '0;
    o.pc = m_pc;
    o.fa = m_pc;
    o.rp = (m_pend.size() != 0);
    b    = best_live(i, any);
    case (m_mode)
      0: o.fa = RESET_PC;
      1: begin
        o.fv = 1'b1;
        o.fi = any;
        o.fd = i.trap || i.br;
        if (!i.stall) begin
          if (any) begin
            o.fa = b.tgt; o.mis = b.mis;
          end else if (m_pend.size() != 0) begin
            o.fa = m_pend[0].tgt; o.mis = m_pend[0].mis;
          end else begin
            o.fa = m_pc + 32'd4;
          end
        end
      end
      default: begin
        o.hl = 1'b1;
        if (i.trap) begin
          o.fa = TRAP_VEC & ~32'h3; o.fi = 1'b1; o.fd = 1'b1;
        end
      end
    endcase
    return o;
  endfunction

  task automatic model_advance(in_t i, out_t o);
    bit   any;
    req_t b;
    b = best_live(i, any);
    if (!i.rst_n) begin
      m_mode = 0; m_pc = RESET_PC; m_pend.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (i.stall) begin
        if (any && (m_pend.size() == 0 || b.prio >= m_pend[0].prio)) begin
          m_pend.delete();
          m_pend.push_back(b);
        end
      end else begin
        m_pc = o.fa;
        m_pend.delete();
        if (i.halt) m_mode = 2;
      end
    end else begin
      m_pend.delete();
      if (i.trap) begin
        m_pc = TRAP_VEC & ~32'h3; m_mode = 1;
      end else if (i.res) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic drive(in_t i);
    rst = i.rst_n; stall = i.stall; trap_req = i.trap;
    br_req = i.br; br_target = i.bt; jmp_req = i.jmp; jmp_target = i.jt;
    halt_req = i.halt; resume = i.res;
  endtask

  function automatic out_t sample();
    return '{pc, fetch_addr, fetch_valid, flush_if, flush_id, redirect_pending, misalign, halted};
  endfunction

  task automatic check(string name, out_t act, out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got pc=%h fa=%h fv=%b fi=%b fd=%b rp=%b mis=%b hl=%b, want pc=%h fa=%h fv=%b fi=%b fd=%b rp=%b mis=%b hl=%b",
               name, act.pc, act.fa, act.fv, act.fi, act.fd, act.rp, act.mis, act.hl,
               exp.pc, exp.fa, exp.fv, exp.fi, exp.fd, exp.rp, exp.mis, exp.hl);
    end
  endtask

  function automatic vec_t mk(logic chk, logic rn, logic st, logic tr, logic br, logic [31:0] bt,
                              logic jm, logic [31:0] jt, logic hlt, logic rs,
                              logic [31:0] epc, logic [31:0] efa, logic fv, logic fi, logic fd,
                              logic rp, logic mis, logic hl);
    vec_t v;
    v.chk = chk;
    v.i   = '{rn, st, tr, br, bt, jm, jt, hlt, rs};
    v.o   = '{epc, efa, fv, fi, fd, rp, mis, hl};
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    in_t  ri;
    out_t eo;
    drive('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0});

    //           chk rn st tr br bt            jm jt            hl rs  pc            fa            fv fi fd rp mi hl
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h4,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h4,         32'h8,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h8,         32'hC,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 32'h20,        0, 0, 32'hC,         32'h20,        1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 32'h80,        1, 32'h40,        0, 0, 32'h20,        32'h100,       1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h80,        1, 32'h40,        0, 0, 32'h100,       32'h80,        1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 32'h10,        0, 0, 32'h80,        32'h10,        1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         1, 32'h40,        0, 0, 32'h10,        32'h10,        1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 32'h80,        0, 32'h0,         0, 0, 32'h10,        32'h10,        1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         1, 32'h40,        0, 0, 32'h10,        32'h10,        1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h10,        32'h80,        1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h80,        32'h84,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 32'h30,        0, 0, 32'h84,        32'h30,        1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h30,        32'h34,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h200,       0, 32'h0,         0, 0, 32'h34,        32'h34,        0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h34,        32'h34,        0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h34,        32'h38,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h83,        0, 32'h0,         0, 0, 32'h38,        32'h80,        1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h80,        32'h84,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h84,        32'hFFFF_FFFC, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'hFFFF_FFFC, 32'h0,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h4,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 32'h60,        0, 32'h0,         0, 0, 32'h4,         32'h4,         1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h4,         32'h4,         1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h4,         32'h4,         1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         32'h4,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h4,         32'h8,         1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8,         32'h100,       0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h100,       32'h104,       1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         1, 32'h40,        0, 0, 32'h104,       32'h104,       1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h90,        0, 32'h0,         0, 0, 32'h104,       32'h90,        1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h90,        32'h94,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h94,        32'h94,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h94,        32'h98,        1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h98,        32'h9C,        1, 0, 0, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1;
      if (vecs[k].chk) check($sformatf("vec%0d", k), sample(), vecs[k].o);
    end

    // Random phase: first cycle is an unchecked reset to sync the model.
    @(negedge clk);
    ri = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    drive(ri);
    eo = model_out(ri);
    @(posedge clk);
    model_advance(ri, eo);

    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      ri.rst_n = ($urandom_range(0, 59) != 0);
      ri.stall = ($urandom_range(0, 9) < 4);
      ri.trap  = ($urandom_range(0, 19) == 0);
      ri.br    = ($urandom_range(0, 6) == 0);
      ri.bt    = $urandom;
      ri.jmp   = ($urandom_range(0, 5) == 0);
      ri.jt    = (n % 97 == 0) ? 32'hFFFF_FFFC : $urandom;
      ri.halt  = ($urandom_range(0, 14) == 0);
      ri.res   = ($urandom_range(0, 3) == 0);
      drive(ri);
      eo = model_out(ri);
      #1;
      check($sformatf("rand%0d", n), sample(), eo);
      @(posedge clk);
      model_advance(ri, eo);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls the instruction-fetch PC register and the next-PC address presented to the synchronous instruction memory. It arbitrates redirect requests from trap, EX-stage branch, and ID-stage jump sources, and holds the PC during pipeline stalls. Redirects that arrive under a stall are buffered and applied when the stall clears. It also generates the IF/ID flush strobes and runs the boot/run/halt sequencing for the front end.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- TRAP_VEC, 32'h0000_0100, redirect target for trap_req

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-low (rst=0 sampled at a clk edge resets)
- stall  in  1  downstream cannot accept; hold PC
- br_req  in  1  EX-stage taken branch
- br_target  in  32  branch target
- jmp_req  in  1  ID-stage jump
- jmp_target  in  32  jump target
- trap_req  in  1  trap; target TRAP_VEC
- halt_req  in  1  enter HALT after the current step
- resume  in  1  leave HALT
- fetch_addr  out  32  combinational address to instruction memory (next PC)
- pc  out  32  registered PC; instruction-memory data aligns with this value
- fetch_valid  out  1  pc/instruction pair is valid this cycle
- flush_if  out  1  squash IF/ID register
- flush_id  out  1  squash ID/EX register
- redirect_pending  out  1  buffered redirect waiting on stall
- misalign  out  1  one-cycle pulse: accepted target had bits[1:0] != 0
- halted  out  1  state == HALT

## Operation

- States: BOOT, RUN, HALT.
- Reset (rst=0 at edge):
  - state=BOOT, pc=RESET_PC, pending cleared.
  - fetch_valid=0, flush_if=0, flush_id=0, misalign=0, redirect_pending=0, halted=0.
- BOOT:
  - fetch_addr=RESET_PC.
  - Next edge: state goes to RUN, pc stays RESET_PC.
  - All requests are ignored.
- RUN, next-PC selection priority, highest first:
  1. trap_req → TRAP_VEC
  2. br_req → br_target
  3. jmp_req → jmp_target
  4. pending redirect
  5. pc+4
- Live requests beat a pending redirect; a pending redirect is cleared when it is applied or overridden.
- Targets are forced to {target[31:2],2'b00}. misalign pulses in the cycle the misaligned target is selected.
- Flushes are combinational, asserted in the cycle a request is sampled, regardless of stall:
  - trap_req or br_req → flush_if=1 and flush_id=1.
  - jmp_req alone → flush_if=1 only.
- RUN with stall=0:
  - fetch_addr = selected next PC.
  - pc <= fetch_addr.
- RUN with stall=1:
  - fetch_addr=pc, so the memory re-reads the same word and the instruction stays stable; pc holds.
  - The highest-priority live request is captured into pending.
  - A new request of equal or higher priority than the stored one overwrites it; a lower-priority request is dropped.
  - redirect_pending=1 while pending is occupied.
- halt_req in RUN with stall=0:
  - pc takes the selected next PC, then state goes to HALT.
  - If stall=1, halt_req is ignored until stall=0.
- HALT:
  - fetch_addr=pc, fetch_valid=0, halted=1.
  - br_req and jmp_req are ignored; pending is cleared on entry.
  - trap_req → pc<=TRAP_VEC, state goes to RUN (trap wins over resume).
  - resume → state goes to RUN, pc unchanged; the instruction at pc is re-fetched.
- fetch_valid=1 when state==RUN; it is 0 in BOOT and HALT.
- Address arithmetic is 32-bit with wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Timing

- Instruction memory reads fetch_addr at the clk edge, so data for pc is valid in the same cycle pc holds that value. Fetch latency from address to pc/instruction pair is 1 cycle.
- Redirect latency is 1 cycle: a request sampled at edge N with stall=0 makes pc = target after edge N.
- Buffered redirect: stall drops in cycle M → pc = pending target after edge M, and redirect_pending falls the same edge.
- Simultaneous stall deassert and a new request: the new request wins and pending is discarded.
- First valid fetch is the second cycle after rst release:
  - Cycle 1: BOOT.
  - Cycle 2: RUN, pc=RESET_PC, fetch_valid=1.
- Reset mid-stall or mid-HALT overrides everything at the sampled edge.

## Test plan

- Reset with RESET_PC=0:
  - Release rst → one BOOT cycle (fetch_valid=0), then pc=0, 4, 8, 12 on consecutive cycles with fetch_valid=1.
- Priority:
  - pc=0x20; trap_req, br_req(0x80) and jmp_req(0x40) in the same cycle → pc=0x100 next cycle, flush_if=flush_id=1.
  - br_req and jmp_req alone → pc=0x80, flush_id=1.
- Stall buffering:
  - stall=1 at pc=0x10; jmp_req(0x40) in cycle 1, br_req(0x80) in cycle 2 → redirect_pending=1, pc holds 0x10.
  - stall drops → pc=0x80, then 0x84.
- Lower priority dropped:
  - Pending br(0x80) under stall; jmp_req(0x40) arrives → dropped; release → pc=0x80.
- Halt/resume:
  - halt_req at pc=0x30 → pc=0x34, halted=1, fetch_valid=0.
  - br_req while halted → ignored.
  - resume → pc=0x34 with fetch_valid=1, then 0x38.
- Misalign and wrap:
  - br_target=0x83 → pc=0x80, misalign pulse for 1 cycle.
  - pc=0xFFFF_FFFC → next pc=0x0000_0000.
  - rst=0 during stall with pending → all outputs at reset values next cycle.
